// File: rtl/vga_timing_gen.sv
// Two-mode VGA timing generator: fractional pixel enable, h/v counters, and a delay-matched output pipeline.
// Optional VGA_LINE_MATCH_EN adds line_cmp_i / line_match_o, which pulse on the line_start of a chosen line.
module vga_timing_gen #(
  parameter int PIX_NUM   = 1,
  parameter int PIX_DEN   = 2,
  parameter int CNT_W     = 11,
  parameter int X_POS_W   = 10,
  parameter int Y_POS_W   = 9,
  parameter int OUT_DELAY = 0,
  parameter int M0_H_RES  = 640,
  parameter int M0_H_FP   = 16,
  parameter int M0_H_SYNC = 96,
  parameter int M0_H_BP   = 48,
  parameter int M0_V_RES  = 480,
  parameter int M0_V_FP   = 10,
  parameter int M0_V_SYNC = 2,
  parameter int M0_V_BP   = 33,
  parameter bit M0_HS_POL = 1'b0,
  parameter bit M0_VS_POL = 1'b0,
  parameter int M1_H_RES  = 640,
  parameter int M1_H_FP   = 16,
  parameter int M1_H_SYNC = 96,
  parameter int M1_H_BP   = 48,
  parameter int M1_V_RES  = 350,
  parameter int M1_V_FP   = 37,
  parameter int M1_V_SYNC = 2,
  parameter int M1_V_BP   = 60,
  parameter bit M1_HS_POL = 1'b1,
  parameter bit M1_VS_POL = 1'b0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               mode_i,
`ifdef VGA_LINE_MATCH_EN
  input  logic [CNT_W-1:0]   line_cmp_i,
  output logic               line_match_o,
`endif
  output logic               pixel_en_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic [X_POS_W-1:0] pixel_x_o,
  output logic [Y_POS_W-1:0] pixel_y_o,
  output logic               visible_range_o,
  output logic               line_start_o,
  output logic               frame_start_o,
  output logic               mode_o
);

  localparam int AW = $clog2(PIX_DEN) + 1;

  localparam logic [CNT_W-1:0] M0_HR  = CNT_W'(M0_H_RES);
  localparam logic [CNT_W-1:0] M0_HSS = CNT_W'(M0_H_RES + M0_H_FP);
  localparam logic [CNT_W-1:0] M0_HSE = CNT_W'(M0_H_RES + M0_H_FP + M0_H_SYNC);
  localparam logic [CNT_W-1:0] M0_HL  = CNT_W'(M0_H_RES + M0_H_FP + M0_H_SYNC + M0_H_BP - 1);
  localparam logic [CNT_W-1:0] M0_VR  = CNT_W'(M0_V_RES);
  localparam logic [CNT_W-1:0] M0_VSS = CNT_W'(M0_V_RES + M0_V_FP);
  localparam logic [CNT_W-1:0] M0_VSE = CNT_W'(M0_V_RES + M0_V_FP + M0_V_SYNC);
  localparam logic [CNT_W-1:0] M0_VL  = CNT_W'(M0_V_RES + M0_V_FP + M0_V_SYNC + M0_V_BP - 1);
  localparam logic [CNT_W-1:0] M1_HR  = CNT_W'(M1_H_RES);
  localparam logic [CNT_W-1:0] M1_HSS = CNT_W'(M1_H_RES + M1_H_FP);
  localparam logic [CNT_W-1:0] M1_HSE = CNT_W'(M1_H_RES + M1_H_FP + M1_H_SYNC);
  localparam logic [CNT_W-1:0] M1_HL  = CNT_W'(M1_H_RES + M1_H_FP + M1_H_SYNC + M1_H_BP - 1);
  localparam logic [CNT_W-1:0] M1_VR  = CNT_W'(M1_V_RES);
  localparam logic [CNT_W-1:0] M1_VSS = CNT_W'(M1_V_RES + M1_V_FP);
  localparam logic [CNT_W-1:0] M1_VSE = CNT_W'(M1_V_RES + M1_V_FP + M1_V_SYNC);
  localparam logic [CNT_W-1:0] M1_VL  = CNT_W'(M1_V_RES + M1_V_FP + M1_V_SYNC + M1_V_BP - 1);

  typedef struct packed {
    logic               hs;
    logic               vs;
    logic [X_POS_W-1:0] x;
    logic [Y_POS_W-1:0] y;
    logic               vis;
    logic               ls;
    logic               fs;
    logic               mode;
`ifdef VGA_LINE_MATCH_EN
    logic               lm;
`endif
  } stage_t;

  logic [AW-1:0]    r_acc;
  logic             r_pix_en;
  logic [CNT_W-1:0] r_h, r_v;
  logic             r_mode;
  logic             r_wrap;
  stage_t           r_st [0:OUT_DELAY];

  logic [AW:0]      w_sum;
  logic             w_en;
  logic [CNT_W-1:0] w_hr, w_hss, w_hse, w_hl, w_vr, w_vss, w_vse, w_vl;
  logic             w_hs_pol, w_vs_pol, w_h_max, w_v_max;
  stage_t           w_dec, w_rst;

  assign w_sum = {1'b0, r_acc} + (AW+1)'(PIX_NUM);
  assign w_en  = (w_sum >= (AW+1)'(PIX_DEN));

  assign w_hr     = r_mode ? M1_HR  : M0_HR;
  assign w_hss    = r_mode ? M1_HSS : M0_HSS;
  assign w_hse    = r_mode ? M1_HSE : M0_HSE;
  assign w_hl     = r_mode ? M1_HL  : M0_HL;
  assign w_vr     = r_mode ? M1_VR  : M0_VR;
  assign w_vss    = r_mode ? M1_VSS : M0_VSS;
  assign w_vse    = r_mode ? M1_VSE : M0_VSE;
  assign w_vl     = r_mode ? M1_VL  : M0_VL;
  assign w_hs_pol = r_mode ? M1_HS_POL : M0_HS_POL;
  assign w_vs_pol = r_mode ? M1_VS_POL : M0_VS_POL;
  assign w_h_max  = (r_h == w_hl);
  assign w_v_max  = (r_v == w_vl);

  // Mode only changes on the frame-wrap edge, so counters and mode always describe the same frame.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc    <= '0;
      r_pix_en <= 1'b0;
      r_h      <= '0;
      r_v      <= '0;
      r_mode   <= mode_i;
      r_wrap   <= 1'b0;
    end else begin
      r_acc    <= w_en ? AW'(w_sum - (AW+1)'(PIX_DEN)) : AW'(w_sum);
      r_pix_en <= w_en;
      r_wrap   <= w_en && w_h_max;
      if (w_en) begin
        if (w_h_max) begin
          r_h <= '0;
          if (w_v_max) begin
            r_v    <= '0;
            r_mode <= mode_i;
          end else begin
            r_v <= r_v + 1'b1;
          end
        end else begin
          r_h <= r_h + 1'b1;
        end
      end
    end
  end

  // r_wrap marks that h just entered 0, so the strobes line up with pixel_x_o == 0.
  always_comb begin
    w_dec      = '0;
    w_dec.hs   = ((r_h >= w_hss) && (r_h < w_hse)) ^ ~w_hs_pol;
    w_dec.vs   = ((r_v >= w_vss) && (r_v < w_vse)) ^ ~w_vs_pol;
    w_dec.x    = r_h[X_POS_W-1:0];
    w_dec.y    = r_v[Y_POS_W-1:0];
    w_dec.vis  = (r_h < w_hr) && (r_v < w_vr);
    w_dec.ls   = r_wrap;
    w_dec.fs   = r_wrap && (r_v == '0);
    w_dec.mode = r_mode;
`ifdef VGA_LINE_MATCH_EN
    w_dec.lm   = r_wrap && (r_v == line_cmp_i);
`endif
  end

  always_comb begin
    w_rst      = '0;
    w_rst.hs   = mode_i ? ~M1_HS_POL : ~M0_HS_POL;
    w_rst.vs   = mode_i ? ~M1_VS_POL : ~M0_VS_POL;
    w_rst.mode = mode_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i <= OUT_DELAY; i++) r_st[i] <= w_rst;
    end else begin
      r_st[0] <= w_dec;
      for (int i = 1; i <= OUT_DELAY; i++) r_st[i] <= r_st[i-1];
    end
  end

  assign pixel_en_o      = r_pix_en;
  assign hsync_o         = r_st[OUT_DELAY].hs;
  assign vsync_o         = r_st[OUT_DELAY].vs;
  assign pixel_x_o       = r_st[OUT_DELAY].x;
  assign pixel_y_o       = r_st[OUT_DELAY].y;
  assign visible_range_o = r_st[OUT_DELAY].vis;
  assign line_start_o    = r_st[OUT_DELAY].ls;
  assign frame_start_o   = r_st[OUT_DELAY].fs;
  assign mode_o          = r_st[OUT_DELAY].mode;
`ifdef VGA_LINE_MATCH_EN
  assign line_match_o    = r_st[OUT_DELAY].lm;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Second-generation VGA timing generator.
- Produces sync, pixel coordinates, blanking and strobe signals for two compile-time timing modes, selected at runtime.
- Features:
  - fractional pixel-clock enable derived from the system clock;
  - per-mode sync polarity;
  - line_start/frame_start strobes;
  - configurable output pipeline delay, so sync aligns with downstream pixel-generation latency.
- Sits between the system clock domain and the pong renderer / RGB output logic.

Parameters:
- PIX_NUM, 1: numerator of the pixel-enable rate, pixel_rate = clk_rate * PIX_NUM / PIX_DEN.
- PIX_DEN, 2: denominator; must satisfy PIX_DEN >= PIX_NUM >= 1.
- CNT_W, 11: width of the internal h/v counters; must hold the largest H_TOTAL-1 and V_TOTAL-1.
- X_POS_W, 10: width of pixel_x_o.
- Y_POS_W, 9: width of pixel_y_o.
- OUT_DELAY, 0: extra register stages (clk cycles) on all outputs except pixel_en_o; range 0..7.
- M0_H_RES / M0_H_FP / M0_H_SYNC / M0_H_BP, 640 / 16 / 96 / 48: mode 0 horizontal timing, in pixels.
- M0_V_RES / M0_V_FP / M0_V_SYNC / M0_V_BP, 480 / 10 / 2 / 33: mode 0 vertical timing, in lines.
- M0_HS_POL / M0_VS_POL, 0 / 0: mode 0 sync active level.
- M1_H_RES / M1_H_FP / M1_H_SYNC / M1_H_BP, 640 / 16 / 96 / 48: mode 1 horizontal timing.
- M1_V_RES / M1_V_FP / M1_V_SYNC / M1_V_BP, 350 / 37 / 2 / 60: mode 1 vertical timing.
- M1_HS_POL / M1_VS_POL, 1 / 0: mode 1 sync active level.

Ports:
- clk_i, input, 1: system clock.
- rst_i, input, 1: synchronous, active-high reset.
- mode_i, input, 1: requested timing mode; sampled only at the frame boundary.
- pixel_en_o, output, 1: pixel-rate enable, one clk wide; not delayed by OUT_DELAY.
- hsync_o, output, 1: horizontal sync, polarity per the active mode.
- vsync_o, output, 1: vertical sync, polarity per the active mode.
- pixel_x_o, output, X_POS_W: current horizontal count, truncated.
- pixel_y_o, output, Y_POS_W: current vertical count, truncated.
- visible_range_o, output, 1: high inside the active area.
- line_start_o, output, 1: one-clk pulse when h count enters 0.
- frame_start_o, output, 1: one-clk pulse when h and v counts both enter 0.
- mode_o, output, 1: currently active mode.

Behaviour:
- Pixel enable:
  - Phase accumulator acc, width $clog2(PIX_DEN)+1, reset to 0.
  - Each clk: if acc + PIX_NUM >= PIX_DEN, then acc <= acc + PIX_NUM - PIX_DEN and en = 1; else acc <= acc + PIX_NUM and en = 0.
  - pixel_en_o is en, registered: 1 clk latency.
  - PIX_NUM == PIX_DEN gives en = 1 every cycle.
- Totals per mode:
  - H_TOTAL = RES + FP + SYNC + BP; V_TOTAL likewise.
  - Sync is asserted for RES+FP <= cnt < RES+FP+SYNC.
  - Mode 0 totals: 800 x 525. Mode 1 totals: 800 x 449.
- h_cnt:
  - Advances only when en = 1.
  - Wraps to 0 after H_TOTAL-1 of the active mode.
- v_cnt:
  - Advances when en = 1 and h_cnt = H_TOTAL-1.
  - Wraps to 0 after V_TOTAL-1.
- Mode switch:
  - active_mode <= mode_i only on the frame-wrap cycle (en, h max, v max), so the new mode starts with the counters at (0,0).
  - Changes to mode_i mid-frame are ignored until that point; no partial frames occur.
- Reset:
  - h_cnt, v_cnt and acc go to 0; active_mode <= mode_i.
  - All delay-pipeline registers are cleared.
  - After reset, every output shows its inactive value:
    - hsync_o = ~HS_POL and vsync_o = ~VS_POL of the mode sampled at reset;
    - pixel_x_o = 0, pixel_y_o = 0;
    - visible_range_o, line_start_o, frame_start_o and pixel_en_o = 0;
    - mode_o = mode_i.
  - Reset mid-line aborts the frame immediately.
- Output stage:
  - Stage 0 registers the decoded values from the counters each clk (1 clk latency).
  - hsync/vsync are XORed with the inverse polarity so the active level equals HS_POL/VS_POL.
  - visible_range = (h_cnt < H_RES) && (v_cnt < V_RES).
  - line_start = en && h_cnt wraps to 0 this cycle. frame_start = line_start && v_cnt wraps to 0.
  - OUT_DELAY further stages are applied identically to all delayed outputs.
  - Total latency from counter change to output = 1 + OUT_DELAY clk.
- Width rules:
  - pixel_x_o / pixel_y_o are the low bits of the counters.
  - Counter comparisons are done at full CNT_W width.

Optional Feature:
- Macro: VGA_LINE_MATCH_EN.
- When defined:
  - adds input line_cmp_i [CNT_W-1:0];
  - adds output line_match_o, a one-clk pulse aligned with line_start_o when the new v count equals line_cmp_i. This lets the game logic update paddle and ball state during blanking.
  - line_cmp_i is sampled every clk.
  - line_match_o resets to 0 and follows the same OUT_DELAY pipeline.
- When undefined: the ports and logic are absent.

Test Plan:
- Defaults, mode_i = 0, rst_i for 3 clk:
  - pixel_en_o toggles every 2nd clk.
  - One frame is 800*525*2 = 840000 clk, with exactly one frame_start_o pulse.
  - hsync_o is low for 96 enables starting at x = 656.
  - vsync_o is low on lines 490-491.
- mode_i = 1 from reset:
  - V_TOTAL = 449; hsync_o is high (active) for x = 656..751 and idle low.
  - visible_range_o is high only for y < 350.
- Toggle mode_i 0 -> 1 at line 100 of a mode 0 frame:
  - Mode 0 timing continues to line 524.
  - mode_o changes to 1 on the frame-wrap cycle; the next frame is 449 lines.
- PIX_NUM = 2, PIX_DEN = 5:
  - Over 5000 clk, exactly 2000 pixel_en_o pulses, with the spacing pattern 2,3,2,3.
- OUT_DELAY = 3:
  - All delayed outputs lag the OUT_DELAY = 0 instance by exactly 3 clk.
  - pixel_en_o is unchanged.
- Assert rst_i at x = 300, y = 200:
  - The next clk after release shows counters at (0,0) and outputs inactive.
  - The first frame_start_o pulse occurs 840000 clk later (defaults).
